// File: rtl/sm_hex_pkg.sv
// Shared types and constants for the seven-segment hex scan driver.
package sm_hex_pkg;

    // Scanner FSM: parked with counters at zero, or actively stepping through digits.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scanState_t;

    // All segments dark, active-high form. Polarity is applied at the output register.
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high hex glyphs, bit order {g,f,e,d,c,b,a}. Lower-case b and d keep them
    // distinguishable from 8 and 0.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sm_hex_to_seg.sv
// Nibble to active-high seven-segment glyph lookup.
module sm_hex_to_seg
    import sm_hex_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    // Pure table lookup; no polarity handling here.
    always_comb begin
        glyph_o = GLYPH_TABLE[nibble_i];
    end

endmodule

// File: rtl/sm_hex_scan.sv
// Time-multiplexed seven-segment scan driver. Captures the input value once per frame,
// walks the digits one prescaler slot at a time, and darkens the anodes for the first
// part of every slot so the previous digit's segments cannot ghost onto the next one.
module sm_hex_scan
    import sm_hex_pkg::*;
#(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned BLANK       = 1000,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          AN_ACT_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   number,
    input  logic                  enable,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_start
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DigW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PreW-1:0] PRE_LAST   = PreW'(PRESCALE - 1);
    localparam logic [DigW-1:0] DIGIT_LAST = DigW'(DIGITS - 1);
    localparam logic [PreW-1:0] BLANK_CMP  = PreW'(BLANK);

    // Dark levels of the physical pins after polarity is applied.
    localparam logic [6:0]        SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] AN_IDLE  = AN_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Elaboration-time parameter sanity.
    if (PRESCALE < 2) begin : gPrescaleCheck
        $error("sm_hex_scan: PRESCALE must be at least 2");
    end
    if (BLANK >= PRESCALE) begin : gBlankCheck
        $error("sm_hex_scan: BLANK must be smaller than PRESCALE");
    end

    scanState_t          stateQ, stateD;
    logic [PreW-1:0]     preQ, preD;
    logic [DigW-1:0]     digitQ, digitD;
    logic [4*DIGITS-1:0] snapshotQ, snapshotD;

    logic [6:0]          segQ, segD;
    logic [DIGITS-1:0]   anodeQ, anodeD;
    logic                frameStartQ, frameStartD;

    logic [3:0]          curNibble;
    logic                digitBlanked;
    logic                slotLit;
    logic [6:0]          glyph;
    logic [6:0]          segHigh;
    logic [DIGITS-1:0]   anodeHigh;

    // State, counters and snapshot; reset is synchronous and overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            preQ      <= '0;
            digitQ    <= '0;
            snapshotQ <= '0;
        end else begin
            stateQ    <= stateD;
            preQ      <= preD;
            digitQ    <= digitD;
            snapshotQ <= snapshotD;
        end
    end

    // Next-state logic: slot prescaler, digit pointer and once-per-frame capture.
    always_comb begin
        stateD    = stateQ;
        preD      = preQ;
        digitD    = digitQ;
        snapshotD = snapshotQ;
        unique case (stateQ)
            IDLE: begin
                preD   = '0;
                digitD = '0;
                if (enable) begin
                    stateD    = SCAN;
                    snapshotD = number;
                end
            end
            SCAN: begin
                if (!enable) begin
                    stateD = IDLE;
                    preD   = '0;
                    digitD = '0;
                end else if (preQ == PRE_LAST) begin
                    preD = '0;
                    if (digitQ == DIGIT_LAST) begin
                        // Frame boundary: only here may a new value reach the display.
                        digitD    = '0;
                        snapshotD = number;
                    end else begin
                        digitD = digitQ + DigW'(1);
                    end
                end else begin
                    preD = preQ + PreW'(1);
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Select the current nibble and decide leading-zero blanking, scanning from the top
    // digit down so upperZero means "this nibble and everything above it is zero".
    always_comb begin
        logic upperZero;
        upperZero    = 1'b1;
        curNibble    = 4'h0;
        digitBlanked = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            upperZero = upperZero & (snapshotQ[4*i +: 4] == 4'h0);
            if (digitQ == DigW'(i)) begin
                curNibble    = snapshotQ[4*i +: 4];
                digitBlanked = blank_lz && (i != 0) && upperZero;
            end
        end
    end

    sm_hex_to_seg uGlyph (
        .nibble_i (curNibble),
        .glyph_o  (glyph)
    );

    // Output decode from the current counters; registered below so pins lag by one cycle.
    always_comb begin
        slotLit     = (stateQ == SCAN) && (preQ >= BLANK_CMP) && !digitBlanked;
        anodeHigh   = '0;
        segHigh     = SEG_OFF;
        if (slotLit) begin
            anodeHigh[digitQ] = 1'b1;
            segHigh           = glyph;
        end
        segD        = SEG_ACT_LOW ? ~segHigh : segHigh;
        anodeD      = AN_ACT_LOW ? ~anodeHigh : anodeHigh;
        // Digit 0 at slot start is only reachable right after a snapshot load.
        frameStartD = (stateQ == SCAN) && (preQ == '0) && (digitQ == '0);
    end

    // Output registers, forced dark on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segQ        <= SEG_IDLE;
            anodeQ      <= AN_IDLE;
            frameStartQ <= 1'b0;
        end else begin
            segQ        <= segD;
            anodeQ      <= anodeD;
            frameStartQ <= frameStartD;
        end
    end

    assign seg         = segQ;
    assign anode       = anodeQ;
    assign frame_start = frameStartQ;

endmodule
